// File: rtl/gbe_bframe_status_if.sv
// rtl/gbe_bframe_status_if.sv - TX word stream, control and status signals of gbe_bframe_status
interface gbe_bframe_status_if;
    logic        in_valid;
    logic        in_eof;
    logic        in_overflow;
    logic        in_link_up;
    logic        ctrl_clr;
    logic [31:0] user_data_out;
    logic        frame_done;
    logic        frame_bad;

    modport master (
        output in_valid, in_eof, in_overflow, in_link_up, ctrl_clr,
        input  user_data_out, frame_done, frame_bad
    );

    modport slave (
        input  in_valid, in_eof, in_overflow, in_link_up, ctrl_clr,
        output user_data_out, frame_done, frame_bad
    );
endinterface

// File: rtl/gbe_bframe_status.sv
// rtl/gbe_bframe_status.sv - per-frame GbE TX status word; length check enabled by BFRAME_LEN_CHECK_EN
module gbe_bframe_status #(
    parameter int EXP_LEN = 128,
    parameter int LEN_W   = 16
) (
    input  logic               user_clk,
    input  logic               user_rst,
    gbe_bframe_status_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FRAME   = 2'd1,
        S_DISCARD = 2'd2,
        S_ILLEGAL = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        err_q, err_d;
    logic        done_q, done_d;
    logic        bad_q, bad_d;
    logic        link_q;
    logic        ovf_q, ovf_d;
    logic [11:0] bad_cnt_q, bad_cnt_d;
    logic [15:0] good_cnt_q, good_cnt_d;
    logic        err_now;
    logic        len_bad;

    assign err_now = bus.in_overflow | ~bus.in_link_up;

`ifdef BFRAME_LEN_CHECK_EN
    logic [LEN_W-1:0] len_q, len_d, len_next;

    // len_q is zero whenever idle, so len_next is the word count including the current word
    assign len_next = (len_q == {LEN_W{1'b1}}) ? len_q : len_q + LEN_W'(1);
    assign len_bad  = (len_next != LEN_W'(EXP_LEN));

    always_comb begin
        len_d = len_q;
        if (state_d == S_IDLE) begin
            len_d = '0;
        end else if (bus.in_valid) begin
            len_d = len_next;
        end
    end

    always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst) begin
            len_q <= '0;
        end else begin
            len_q <= len_d;
        end
    end
`else
    logic unused_cfg;
    assign len_bad    = 1'b0;
    assign unused_cfg = (EXP_LEN == LEN_W);
`endif

    always_comb begin
        state_d    = state_q;
        err_d      = err_q;
        done_d     = 1'b0;
        bad_d      = 1'b0;
        ovf_d      = bus.in_overflow | (ovf_q & ~bus.ctrl_clr);
        good_cnt_d = good_cnt_q;
        bad_cnt_d  = bad_cnt_q;

        case (state_q)
            S_IDLE: begin
                err_d = 1'b0;
                if (bus.in_valid) begin
                    if (bus.in_eof) begin
                        done_d = 1'b1;
                        bad_d  = err_now | len_bad;
                    end else begin
                        state_d = S_FRAME;
                        err_d   = err_now;
                    end
                end
            end
            S_FRAME: begin
                if (bus.in_valid && bus.in_eof) begin
                    done_d  = 1'b1;
                    bad_d   = err_q | err_now | len_bad;
                    state_d = S_IDLE;
                    err_d   = 1'b0;
                end else if (err_q || err_now) begin
                    state_d = S_DISCARD;
                    err_d   = 1'b1;
                end
            end
            S_DISCARD: begin
                if (bus.in_valid && bus.in_eof) begin
                    done_d  = 1'b1;
                    bad_d   = 1'b1;
                    state_d = S_IDLE;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                err_d   = 1'b0;
            end
        endcase

        // a clear in the classification cycle drops that frame from both counts
        if (bus.ctrl_clr) begin
            good_cnt_d = '0;
            bad_cnt_d  = '0;
        end else if (done_d) begin
            if (bad_d) begin
                if (bad_cnt_q != 12'hFFF) begin
                    bad_cnt_d = bad_cnt_q + 12'd1;
                end
            end else begin
                good_cnt_d = good_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst) begin
            state_q    <= S_IDLE;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            bad_q      <= 1'b0;
            link_q     <= 1'b0;
            ovf_q      <= 1'b0;
            good_cnt_q <= '0;
            bad_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            err_q      <= err_d;
            done_q     <= done_d;
            bad_q      <= bad_d;
            link_q     <= bus.in_link_up;
            ovf_q      <= ovf_d;
            good_cnt_q <= good_cnt_d;
            bad_cnt_q  <= bad_cnt_d;
        end
    end

    assign bus.user_data_out = {link_q, ovf_q, state_q, bad_cnt_q, good_cnt_q};
    assign bus.frame_done    = done_q;
    assign bus.frame_bad     = bad_q;
endmodule

// File: tb/tb_gbe_bframe_status.sv
// tb/tb_gbe_bframe_status.sv - directed vector bench for gbe_bframe_status
module tb_gbe_bframe_status;
`ifdef BFRAME_LEN_CHECK_EN
    localparam int LC = 1;
`else
    localparam int LC = 0;
`endif

    typedef struct {
        logic        v, e, o, l, c;
        logic        d, b;
        logic [31:0] st;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_fail = 0;
    vec_t vecs[$];

    gbe_bframe_status_if ifa ();
    gbe_bframe_status_if ifb ();

    gbe_bframe_status #(.EXP_LEN(4), .LEN_W(16)) dut_a (
        .user_clk (clk),
        .user_rst (rst),
        .bus      (ifa)
    );

    gbe_bframe_status #(.EXP_LEN(1), .LEN_W(16)) dut_b (
        .user_clk (clk),
        .user_rst (rst),
        .bus      (ifb)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] st(input logic l, input logic o, input logic [1:0] s,
                                       input int b, input int g);
        return {l, o, s, 12'(b), 16'(g)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add(input logic v, input logic e, input logic o, input logic l, input logic c,
                       input logic d, input logic b, input logic [31:0] s);
        vec_t t;
        t.v = v; t.e = e; t.o = o; t.l = l; t.c = c; t.d = d; t.b = b; t.st = s;
        vecs.push_back(t);
    endtask

    task automatic drive_a(input logic v, input logic e, input logic o, input logic l, input logic c);
        ifa.in_valid = v; ifa.in_eof = e; ifa.in_overflow = o; ifa.in_link_up = l; ifa.ctrl_clr = c;
    endtask

    task automatic step_check_a(input string name, input logic d, input logic b, input logic [31:0] s);
        @(posedge clk);
        #1;
        check({name, " done"}, 32'(ifa.frame_done), 32'(d));
        check({name, " bad"}, 32'(ifa.frame_bad), 32'(b));
        check({name, " status"}, ifa.user_data_out, s);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g0, b0, g1, b1;
        g0 = 4 - LC; b0 = LC;
        g1 = 1 - LC; b1 = LC;

        // back-to-back frames of 4,4,4,5 words
        for (int f = 0; f < 3; f++) begin
            for (int w = 0; w < 3; w++) add(1, 0, 0, 1, 0, 0, 0, st(1, 0, 1, 0, f));
            add(1, 1, 0, 1, 0, 1, 0, st(1, 0, 0, 0, f + 1));
        end
        for (int w = 0; w < 4; w++) add(1, 0, 0, 1, 0, 0, 0, st(1, 0, 1, 0, 3));
        add(1, 1, 0, 1, 0, 1, 1'(LC), st(1, 0, 0, b0, g0));
        // overflow on word 2 -> discard
        add(1, 0, 0, 1, 0, 0, 0, st(1, 0, 1, b0, g0));
        add(1, 0, 1, 1, 0, 0, 0, st(1, 1, 2, b0, g0));
        add(1, 0, 0, 1, 0, 0, 0, st(1, 1, 2, b0, g0));
        add(1, 1, 0, 1, 0, 1, 1, st(1, 1, 0, b0 + 1, g0));
        // good frame, sticky overflow stays
        for (int w = 0; w < 3; w++) add(1, 0, 0, 1, 0, 0, 0, st(1, 1, 1, b0 + 1, g0));
        add(1, 1, 0, 1, 0, 1, 0, st(1, 1, 0, b0 + 1, g0 + 1));
        add(0, 1, 0, 1, 0, 0, 0, st(1, 1, 0, b0 + 1, g0 + 1));
        // clear together with overflow, then plain clear
        add(0, 0, 1, 1, 1, 0, 0, st(1, 1, 0, 0, 0));
        add(0, 0, 0, 1, 1, 0, 0, st(1, 0, 0, 0, 0));
        // good frame with a stray unqualified eof inside
        add(1, 0, 0, 1, 0, 0, 0, st(1, 0, 1, 0, 0));
        add(0, 1, 0, 1, 0, 0, 0, st(1, 0, 1, 0, 0));
        add(1, 0, 0, 1, 0, 0, 0, st(1, 0, 1, 0, 0));
        add(1, 0, 0, 1, 0, 0, 0, st(1, 0, 1, 0, 0));
        add(1, 1, 0, 1, 0, 1, 0, st(1, 0, 0, 0, 1));
        // clear lands on eof
        for (int w = 0; w < 3; w++) add(1, 0, 0, 1, 0, 0, 0, st(1, 0, 1, 0, 1));
        add(1, 1, 0, 1, 1, 1, 0, st(1, 0, 0, 0, 0));
        // single-word frame
        add(1, 1, 0, 1, 0, 1, 1'(LC), st(1, 0, 0, b1, g1));
        // link loss on word 2
        add(1, 0, 0, 1, 0, 0, 0, st(1, 0, 1, b1, g1));
        add(1, 0, 0, 0, 0, 0, 0, st(0, 0, 2, b1, g1));
        add(1, 0, 0, 1, 0, 0, 0, st(1, 0, 2, b1, g1));
        add(1, 1, 0, 1, 0, 1, 1, st(1, 0, 0, b1 + 1, g1));
        // overflow only in the eof cycle
        for (int w = 0; w < 3; w++) add(1, 0, 0, 1, 0, 0, 0, st(1, 0, 1, b1 + 1, g1));
        add(1, 1, 1, 1, 0, 1, 1, st(1, 1, 0, b1 + 2, g1));
        // link down on a single-word frame
        add(1, 1, 0, 0, 0, 1, 1, st(0, 1, 0, b1 + 3, g1));

        drive_a(0, 0, 0, 0, 0);
        ifb.in_valid = 0; ifb.in_eof = 0; ifb.in_overflow = 0; ifb.in_link_up = 0; ifb.ctrl_clr = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset a status", ifa.user_data_out, 32'h0);
        check("reset a done", 32'(ifa.frame_done), 32'h0);
        check("reset a bad", 32'(ifa.frame_bad), 32'h0);
        check("reset b status", ifb.user_data_out, 32'h0);
        rst = 0;

        for (int i = 0; i < vecs.size(); i++) begin
            drive_a(vecs[i].v, vecs[i].e, vecs[i].o, vecs[i].l, vecs[i].c);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d done", i), 32'(ifa.frame_done), 32'(vecs[i].d));
            check($sformatf("vec%0d bad", i), 32'(ifa.frame_bad), 32'(vecs[i].b));
            check($sformatf("vec%0d status", i), ifa.user_data_out, vecs[i].st);
        end

        // asynchronous reset mid-frame; the tail is seen as a 3-word frame
        drive_a(1, 0, 0, 1, 0);
        step_check_a("pre-reset w1", 0, 0, st(1, 1, 1, b1 + 3, g1));
        step_check_a("pre-reset w2", 0, 0, st(1, 1, 1, b1 + 3, g1));
        drive_a(0, 0, 0, 1, 0);
        #2 rst = 1;
        #1;
        check("async reset status", ifa.user_data_out, 32'h0);
        check("async reset done", 32'(ifa.frame_done), 32'h0);
        @(posedge clk);
        #1 rst = 0;
        drive_a(1, 0, 0, 1, 0);
        step_check_a("post-reset w1", 0, 0, st(1, 0, 1, 0, 0));
        step_check_a("post-reset w2", 0, 0, st(1, 0, 1, 0, 0));
        drive_a(1, 1, 0, 1, 0);
        step_check_a("post-reset eof", 1, 1'(LC), st(1, 0, 0, b1, g1));
        drive_a(0, 0, 0, 1, 0);

        // counter limits on the EXP_LEN=1 instance: one frame per cycle
        ifb.in_valid = 1; ifb.in_eof = 1; ifb.in_link_up = 1;
        repeat (65535) @(posedge clk);
        #1;
        check("good count 0xFFFF", ifb.user_data_out, st(1, 0, 0, 0, 16'hFFFF));
        check("good frame done", 32'({ifb.frame_done, ifb.frame_bad}), 32'b10);
        @(posedge clk);
        #1;
        check("good count wrap", ifb.user_data_out, st(1, 0, 0, 0, 0));
        ifb.in_overflow = 1;
        repeat (4095) @(posedge clk);
        #1;
        check("bad count 0xFFF", ifb.user_data_out, st(1, 1, 0, 12'hFFF, 0));
        check("bad frame done", 32'({ifb.frame_done, ifb.frame_bad}), 32'b11);
        repeat (5) @(posedge clk);
        #1;
        check("bad count saturated", ifb.user_data_out, st(1, 1, 0, 12'hFFF, 0));
        ifb.in_valid = 0; ifb.in_eof = 0; ifb.in_overflow = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
